// File: rtl/arvi_mem_pkg.sv
// Shared encodings and lane helpers for the data-memory access stage.
// Sizes follow f3[1:0]: 0 = byte, 1 = half, 2 = word.
package arvi_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [4:0] F5_LR = 5'b00010;
  localparam logic [4:0] F5_SC = 5'b00011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: picks the byte/half lane from a bus word and sign/zero extends it.
// Purely combinational; any f3 other than the byte/half codes passes the whole word.
module mem_load_align
  import arvi_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_f3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Data-memory stage: IDLE->ACCESS->DONE over a req/ack bus, stalling upstream until the access retires.
// Best case 3 cycles per access (2 stalled); a failing SC.W retires in 2 cycles without touching the bus.
module mem_stage
  import arvi_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit ATOMIC = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_memread,
  input  logic            i_memwrite,
  input  logic            i_atomic,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_stall,
  output logic            o_ld_misaligned,
  output logic            o_st_misaligned,
  output logic [XLEN-1:0] o_bad_addr,
  output logic            o_bus_en,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [31:0]     o_bus_wdata,
  output logic [3:0]      o_bus_be,
  input  logic            i_bus_ack,
  input  logic [31:0]     i_bus_rdata
);

  mem_state_t       r_state;
  logic             r_bus_en, r_bus_we, r_flush_seen, r_lr, r_resv_vld;
  logic [XLEN-1:0]  r_bus_addr, r_rd_data;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_be;
  logic [2:0]       r_f3;
  logic [1:0]       r_addr_lo;
  logic [XLEN-3:0]  r_resv_addr;

  logic [2:0]  w_f3;
  logic [4:0]  w_f5;
  logic        w_amo, w_lr, w_sc, w_ld_ok, w_st_ok, w_mis, w_start, w_sc_fail;
  logic [31:0] w_ld_data;
  logic        w_unused_inst;

  assign w_f3  = i_inst[14:12];
  assign w_f5  = i_inst[31:27];
  assign w_unused_inst = ^{i_inst[26:15], i_inst[11:0]};

  assign w_amo = ATOMIC && i_atomic;
  assign w_lr  = w_amo && i_memread  && (w_f5 == F5_LR) && (w_f3 == F3_LW);
  assign w_sc  = w_amo && i_memwrite && (w_f5 == F5_SC) && (w_f3 == F3_SW);

  assign w_ld_ok = i_memread && (w_amo ? w_lr :
                   (w_f3 == F3_LB || w_f3 == F3_LH || w_f3 == F3_LW ||
                    w_f3 == F3_LBU || w_f3 == F3_LHU));
  assign w_st_ok = i_memwrite && (w_amo ? w_sc : (w_f3 <= F3_SW));

  assign w_mis = addr_misaligned(w_f3[1:0], i_addr[1:0]);

  assign o_ld_misaligned = (r_state == IDLE) && w_ld_ok && w_mis;
  assign o_st_misaligned = (r_state == IDLE) && w_st_ok && w_mis;
  assign o_bad_addr      = (o_ld_misaligned || o_st_misaligned) ? i_addr : '0;

  assign w_start   = (r_state == IDLE) && (w_ld_ok || w_st_ok) && !w_mis && !i_flush;
  assign w_sc_fail = w_sc && !(r_resv_vld && (r_resv_addr == i_addr[XLEN-1:2]));

  assign o_stall     = w_start || (r_state == ACCESS);
  assign o_rd_data   = (r_state == DONE) ? r_rd_data : '0;
  assign o_bus_en    = r_bus_en;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_be    = r_bus_be;

  mem_load_align u_load_align (
    .i_rdata   (i_bus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_f3      (r_f3),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_bus_en     <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_be     <= '0;
      r_rd_data    <= '0;
      r_f3         <= '0;
      r_addr_lo    <= '0;
      r_lr         <= 1'b0;
      r_flush_seen <= 1'b0;
      r_resv_vld   <= 1'b0;
      r_resv_addr  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_flush_seen <= 1'b0;
          if (w_start) begin
            // Every SC.W consumes the reservation, pass or fail.
            if (w_sc) r_resv_vld <= 1'b0;
            if (w_sc_fail) begin
              r_rd_data <= XLEN'(1);
              r_state   <= DONE;
            end else begin
              r_bus_en    <= 1'b1;
              r_bus_we    <= w_st_ok;
              r_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
              r_bus_be    <= lane_be(w_f3[1:0], i_addr[1:0]);
              r_bus_wdata <= w_st_ok ? lane_wdata(w_f3[1:0], i_wr_data[31:0]) : 32'd0;
              r_f3        <= w_f3;
              r_addr_lo   <= i_addr[1:0];
              r_lr        <= w_lr;
              r_state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (i_bus_ack) begin
            r_bus_en     <= 1'b0;
            r_flush_seen <= 1'b0;
            // The bus cannot abort, so a flush is only honoured once the ack arrives.
            if (r_flush_seen || i_flush) begin
              r_resv_vld <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_rd_data <= r_bus_we ? '0 : XLEN'(w_ld_data);
              if (r_lr) begin
                r_resv_vld  <= 1'b1;
                r_resv_addr <= r_bus_addr[XLEN-1:2];
              end else if (r_bus_we && (r_bus_addr[XLEN-1:2] == r_resv_addr)) begin
                r_resv_vld <= 1'b0;
              end
              r_state <= DONE;
            end
          end else if (i_flush) begin
            r_flush_seen <= 1'b1;
          end
        end
        DONE: begin
          r_rd_data <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected load/SC results popped when the stage retires.
module tb_mem_stage;
  import arvi_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite, atomic, flush, bus_ack;
  logic [31:0] inst, addr, wr_data, bus_rdata;
  logic [31:0] rd_data, bad_addr, bus_addr, bus_wdata;
  logic        stall, ld_mis, st_mis, bus_en, bus_we;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .ATOMIC(1'b1)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_memread(memread), .i_memwrite(memwrite),
    .i_atomic(atomic), .i_inst(inst), .i_addr(addr), .i_wr_data(wr_data),
    .i_flush(flush), .o_rd_data(rd_data), .o_stall(stall),
    .o_ld_misaligned(ld_mis), .o_st_misaligned(st_mis), .o_bad_addr(bad_addr),
    .o_bus_en(bus_en), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_be(bus_be), .i_bus_ack(bus_ack),
    .i_bus_rdata(bus_rdata)
  );

  function automatic logic [31:0] mk_inst(input logic [4:0] f5, input logic [2:0] f3);
    return {f5, 12'h000, f3, 12'h000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic at,
                       input logic [31:0] in, input logic [31:0] ad, input logic [31:0] wd);
    memread = rd; memwrite = wr; atomic = at; inst = in; addr = ad; wr_data = wd;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  // Runs one instruction to retirement, acking after wait_n ACCESS cycles.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic at,
                        input logic [31:0] in, input logic [31:0] ad, input logic [31:0] wd,
                        input int wait_n, input logic [31:0] rdata, input logic exp_acc,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd, input int exp_stalls);
    int stalls, w;
    logic done, bus_seen;
    logic [31:0] e;
    stalls = 0; w = 0; done = 1'b0; bus_seen = 1'b0;
    exp_q.push_back(exp_rd);
    drive(rd, wr, at, in, ad, wd);
    #1;
    for (int c = 0; c < 64; c++) begin
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (bus_en) begin
        if (!bus_seen) begin
          bus_seen = 1'b1;
          chk({tag, " bus_we"}, 32'(bus_we), 32'(wr));
          chk({tag, " bus_addr"}, bus_addr, {ad[31:2], 2'b00});
          chk({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
          if (wr) chk({tag, " bus_wdata"}, bus_wdata, exp_wdata);
        end
        if (w == wait_n) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end else begin
          w++;
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'h0;
    end
    chk({tag, " retired"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " bus_used"}, 32'(bus_seen), 32'(exp_acc));
    e = exp_q.pop_front();
    chk({tag, " rd_data"}, rd_data, e);
    @(posedge clk); #1;
    idle_in();
  endtask

  localparam logic [31:0] I_LB  = {5'd0, 12'h0, F3_LB,  12'h0};
  localparam logic [31:0] I_LH  = {5'd0, 12'h0, F3_LH,  12'h0};
  localparam logic [31:0] I_LW  = {5'd0, 12'h0, F3_LW,  12'h0};
  localparam logic [31:0] I_LBU = {5'd0, 12'h0, F3_LBU, 12'h0};
  localparam logic [31:0] I_LHU = {5'd0, 12'h0, F3_LHU, 12'h0};
  localparam logic [31:0] I_SB  = {5'd0, 12'h0, F3_SB,  12'h0};
  localparam logic [31:0] I_SH  = {5'd0, 12'h0, F3_SH,  12'h0};
  localparam logic [31:0] I_SW  = {5'd0, 12'h0, F3_SW,  12'h0};
  localparam logic [31:0] I_LR  = {F5_LR, 12'h0, F3_LW, 12'h0};
  localparam logic [31:0] I_SC  = {F5_SC, 12'h0, F3_SW, 12'h0};

  initial begin
    logic any_en;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset bus_en", 32'(bus_en), 32'd0);
    chk("reset bus_we", 32'(bus_we), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_wdata", bus_wdata, 32'd0);
    chk("reset bus_be", 32'(bus_be), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("SW", 0, 1, 0, I_SW, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 4);
    run_op("SB", 0, 1, 0, I_SB, 32'h103, 32'h123456A5, 0, 32'h0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0, 2);
    run_op("LB", 1, 0, 0, I_LB, 32'h103, 32'h0, 0, 32'hA5000000, 1, 4'b1000, 32'h0, 32'hFFFFFFA5, 2);
    run_op("LBU", 1, 0, 0, I_LBU, 32'h103, 32'h0, 1, 32'hA5000000, 1, 4'b1000, 32'h0, 32'h000000A5, 3);
    run_op("LH", 1, 0, 0, I_LH, 32'h102, 32'h0, 0, 32'h80010000, 1, 4'b1100, 32'h0, 32'hFFFF8001, 2);
    run_op("LHU", 1, 0, 0, I_LHU, 32'h102, 32'h0, 0, 32'h80010000, 1, 4'b1100, 32'h0, 32'h00008001, 2);
    run_op("LB0", 1, 0, 0, I_LB, 32'h100, 32'h0, 0, 32'h0000007F, 1, 4'b0001, 32'h0, 32'h0000007F, 2);
    run_op("SH", 0, 1, 0, I_SH, 32'h102, 32'h1234BEEF, 0, 32'h0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0, 2);
    run_op("LW", 1, 0, 0, I_LW, 32'h104, 32'h0, 0, 32'h12345678, 1, 4'b1111, 32'h0, 32'h12345678, 2);

    // Misaligned word load: flagged, no stall, never reaches the bus.
    drive(1, 0, 0, I_LW, 32'h102, 32'h0);
    #1;
    chk("LW mis ld_flag", 32'(ld_mis), 32'd1);
    chk("LW mis st_flag", 32'(st_mis), 32'd0);
    chk("LW mis bad_addr", bad_addr, 32'h102);
    chk("LW mis stall", 32'(stall), 32'd0);
    any_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_en = any_en | bus_en;
    end
    chk("LW mis bus_en", 32'(any_en), 32'd0);
    drive(0, 1, 0, I_SH, 32'h101, 32'h0);
    #1;
    chk("SH mis st_flag", 32'(st_mis), 32'd1);
    chk("SH mis bad_addr", bad_addr, 32'h101);
    drive(1, 0, 0, mk_inst(5'd0, 3'd3), 32'h100, 32'h0);
    #1;
    chk("LD f3=3 stall", 32'(stall), 32'd0);
    chk("LD f3=3 flag", 32'(ld_mis), 32'd0);
    @(posedge clk); #1;
    chk("LD f3=3 bus_en", 32'(bus_en), 32'd0);
    idle_in();
    @(posedge clk); #1;

    // Reservation: LR then passing SC, then a failing SC.
    run_op("LR", 1, 0, 1, I_LR, 32'h200, 32'h0, 0, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D, 2);
    run_op("SC ok", 0, 1, 1, I_SC, 32'h200, 32'h00000011, 0, 32'h0, 1, 4'b1111, 32'h00000011, 32'h0, 2);
    run_op("SC fail", 0, 1, 1, I_SC, 32'h200, 32'h00000022, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h1, 1);

    // Store to another word keeps the reservation; store to the reserved word kills it.
    run_op("LR2", 1, 0, 1, I_LR, 32'h200, 32'h0, 0, 32'h1, 1, 4'b1111, 32'h0, 32'h1, 2);
    run_op("SW other", 0, 1, 0, I_SW, 32'h204, 32'h5, 0, 32'h0, 1, 4'b1111, 32'h5, 32'h0, 2);
    run_op("SC keep", 0, 1, 1, I_SC, 32'h200, 32'h6, 0, 32'h0, 1, 4'b1111, 32'h6, 32'h0, 2);
    run_op("LR3", 1, 0, 1, I_LR, 32'h200, 32'h0, 0, 32'h2, 1, 4'b1111, 32'h0, 32'h2, 2);
    run_op("SW same", 0, 1, 0, I_SW, 32'h200, 32'h7, 0, 32'h0, 1, 4'b1111, 32'h7, 32'h0, 2);
    run_op("SC killed", 0, 1, 1, I_SC, 32'h200, 32'h8, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h1, 1);

    // Flush during ACCESS: bus held until ack, DONE skipped, reservation dropped.
    run_op("LR4", 1, 0, 1, I_LR, 32'h200, 32'h0, 0, 32'h3, 1, 4'b1111, 32'h0, 32'h3, 2);
    drive(1, 0, 0, I_LW, 32'h300, 32'h0);
    #1;
    chk("flush start stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("flush access bus_en", 32'(bus_en), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush bus held", 32'(bus_en), 32'd1);
    chk("flush still stalled", 32'(stall), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("flush bus_en dropped", 32'(bus_en), 32'd0);
    chk("flush rd_data", rd_data, 32'h0);
    idle_in();
    run_op("SC after flush", 0, 1, 1, I_SC, 32'h200, 32'h9, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h1, 1);

    // Reset mid-ACCESS abandons the transaction and the reservation.
    run_op("LR5", 1, 0, 1, I_LR, 32'h200, 32'h0, 0, 32'h4, 1, 4'b1111, 32'h0, 32'h4, 2);
    drive(1, 0, 0, I_LW, 32'h400, 32'h0);
    @(posedge clk); #1;
    chk("rst access bus_en", 32'(bus_en), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst bus_en", 32'(bus_en), 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    rst_n = 1'b1;
    idle_in();
    #1;
    chk("rst idle stall", 32'(stall), 32'd0);
    run_op("SC after rst", 0, 1, 1, I_SC, 32'h200, 32'hA, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h1, 1);
    run_op("LW after rst", 1, 0, 0, I_LW, 32'h400, 32'h0, 0, 32'hFEEDFACE, 1, 4'b1111, 32'h0, 32'hFEEDFACE, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
